// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the prescaled UART transmit path.
//   tx_state_e  : frame FSM states (3-bit encoding)
//   START_BIT   : line level during the start bit
//   STOP_BIT    : line level during the stop bit
//   IDLE_LEVEL  : line level between frames
//   PAR_EVEN/PAR_ODD : values of the parity-type select
//   BIT_CNT_W   : width of the per-frame bit counter
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int unsigned BIT_CNT_W = 4;

endpackage

// File: rtl/uart_tx_frame_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_engine_if
// Byte-in / serial-out bundle of the UART transmitter.
//   P_DATA     : parallel payload                (master -> slave)
//   Data_Valid : payload-valid strobe            (master -> slave)
//   PAR_EN     : parity bit enable               (master -> slave)
//   PAR_TYP    : parity type, 0 even / 1 odd     (master -> slave)
//   Prescale   : clock cycles per bit, 0 acts 1  (master -> slave)
//   TX_OUT     : serial line, idle high          (slave -> master)
//   busy       : frame in progress               (slave -> master)
// -----------------------------------------------------------------------------
interface uart_tx_frame_engine_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
);

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [PRESCALE_W-1:0] Prescale;
   logic                  TX_OUT;
   logic                  busy;

   modport master (
      output P_DATA,
      output Data_Valid,
      output PAR_EN,
      output PAR_TYP,
      output Prescale,
      input  TX_OUT,
      input  busy
   );

   modport slave (
      input  P_DATA,
      input  Data_Valid,
      input  PAR_EN,
      input  PAR_TYP,
      input  Prescale,
      output TX_OUT,
      output busy
   );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_timer
// Edge counter (cycles within a bit) and bit counter (bits within a frame).
//   clk_i      : system clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   en_i       : frame in progress; both counters clear while low
//   bit_clr_i  : restart the bit count at this bit boundary
//   prescale_i : cycles per bit, must be >= 1
//   bit_done_o : last cycle of the current bit
//   bit_cnt_o  : bits completed since the last clear
// -----------------------------------------------------------------------------
module uart_tx_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  bit_clr_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic                  bit_done_o,
   output logic [BIT_CNT_W-1:0]  bit_cnt_o
);

   logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

   assign bit_done_o = en_i && (edge_cnt_q == (prescale_i - PRESCALE_W'(1)));
   assign bit_cnt_o  = bit_cnt_q;

   always_comb begin
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      if (!en_i) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
      end else if (bit_done_o) begin
         edge_cnt_d = '0;
         bit_cnt_d  = bit_clr_i ? '0 : bit_cnt_q + BIT_CNT_W'(1);
      end else begin
         edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_engine
// Prescaled UART transmitter: accepts one byte per Data_Valid while idle and
// sends start bit, data LSB first, optional parity bit, one stop bit, each bit
// held for Prescale cycles (Prescale = 0 behaves as 1).
//   CLK : system clock, rising edge
//   RST : asynchronous active-low reset
//   bus : uart_tx_frame_engine_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP,
//         Prescale in; TX_OUT, busy out, both registered)
// Build option: define UART_TX_PARITY_EN to build the PARITY state; without
// it PAR_EN/PAR_TYP are ignored and every frame has no parity bit.
// -----------------------------------------------------------------------------
module uart_tx_frame_engine
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                    CLK,
   input  logic                    RST,
   uart_tx_frame_engine_if.slave   bus
);

   tx_state_e             state_q;
   logic                  tx_q;
   logic                  busy_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [PRESCALE_W-1:0] presc_eff;
   logic                  bit_done;
   logic [BIT_CNT_W-1:0]  bit_cnt;

`ifdef UART_TX_PARITY_EN
   logic                  par_en_q;
   logic                  par_bit_q;
`else
   logic                  unused_par_inputs;
   assign unused_par_inputs = bus.PAR_EN ^ bus.PAR_TYP;
`endif

   assign presc_eff  = (prescale_q == '0) ? PRESCALE_W'(1) : prescale_q;
   assign bus.TX_OUT = tx_q;
   assign bus.busy   = busy_q;

   // Bit count restarts after the start bit so DATA sees 0..DATA_WIDTH-1.
   uart_tx_bit_timer #(
      .PRESCALE_W (PRESCALE_W)
   ) u_bit_timer (
      .clk_i      (CLK),
      .rst_ni     (RST),
      .en_i       (state_q != IDLE),
      .bit_clr_i  (state_q == START),
      .prescale_i (presc_eff),
      .bit_done_o (bit_done),
      .bit_cnt_o  (bit_cnt)
   );

   // TX_OUT is loaded with the level of the bit being entered, so the line
   // changes on the same edge as the state.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         tx_q       <= IDLE_LEVEL;
         busy_q     <= 1'b0;
         shift_q    <= '0;
         prescale_q <= '0;
`ifdef UART_TX_PARITY_EN
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.Data_Valid) begin
                  state_q    <= START;
                  tx_q       <= START_BIT;
                  busy_q     <= 1'b1;
                  shift_q    <= bus.P_DATA;
                  prescale_q <= bus.Prescale;
`ifdef UART_TX_PARITY_EN
                  par_en_q   <= bus.PAR_EN;
                  // Parity is taken from the payload now, before it is shifted out.
                  par_bit_q  <= (^bus.P_DATA) ^ bus.PAR_TYP;
`endif
               end
            end
            START: begin
               if (bit_done) begin
                  state_q <= DATA;
                  tx_q    <= shift_q[0];
                  shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
               end
            end
            DATA: begin
               if (bit_done) begin
                  if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                     if (par_en_q) begin
                        state_q <= PARITY;
                        tx_q    <= par_bit_q;
                     end else begin
                        state_q <= STOP;
                        tx_q    <= STOP_BIT;
                     end
`else
                     state_q <= STOP;
                     tx_q    <= STOP_BIT;
`endif
                  end else begin
                     tx_q    <= shift_q[0];
                     shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_done) begin
                  state_q <= STOP;
                  tx_q    <= STOP_BIT;
               end
            end
`endif
            STOP: begin
               if (bit_done) begin
                  state_q <= IDLE;
                  tx_q    <= IDLE_LEVEL;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= IDLE_LEVEL;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame_engine
// Self-checking bench for uart_tx_frame_engine. Expected line levels come from
// a frame list (start, data LSB first, optional parity, stop) expanded by the
// effective prescale. Parity expectations follow UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame_engine;

   localparam int DW = 8;
   localparam int PW = 6;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b0;

   always #5 CLK = ~CLK;

   uart_tx_frame_engine_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

   uart_tx_frame_engine #(
      .DATA_WIDTH (DW),
      .PRESCALE_W (PW)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   function automatic int eff_presc(input int p);
      return (p == 0) ? 1 : p;
   endfunction

   // Sends one frame and checks every cycle of it plus the following idle cycle.
   // Entered and left at a falling edge. pulse_at >= 0 injects a one-cycle
   // Data_Valid with different inputs mid-frame; hold keeps Data_Valid high.
   task automatic test_frame(input string name, input logic [7:0] d, input bit pe,
                             input bit pt, input int presc, input int pulse_at,
                             input logic [7:0] pulse_d, input bit hold);
      bit bits[$];
      int eff;
      int len;
      int busy_cnt;
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (PAR_BUILT && pe) bits.push_back((^d) ^ pt);
      bits.push_back(1'b1);
      eff      = eff_presc(presc);
      len      = bits.size() * eff;
      busy_cnt = 0;

      bus.P_DATA     = d;
      bus.PAR_EN     = pe;
      bus.PAR_TYP    = pt;
      bus.Prescale   = PW'(presc);
      bus.Data_Valid = 1'b1;
      @(posedge CLK);
      for (int k = 0; k < len; k++) begin
         @(negedge CLK);
         if (k == 0 && !hold) bus.Data_Valid = 1'b0;
         if (k == pulse_at) begin
            bus.Data_Valid = 1'b1;
            bus.P_DATA     = pulse_d;
            bus.PAR_EN     = ~pe;
            bus.PAR_TYP    = ~pt;
            bus.Prescale   = PW'(presc + 3);
         end else if (pulse_at >= 0 && k == pulse_at + 1) begin
            bus.Data_Valid = 1'b0;
         end
         n_checks++;
         if (bus.TX_OUT !== bits[k / eff] || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s line cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=1",
                     name, k, bus.TX_OUT, bus.busy, bits[k / eff]);
         end
         if (bus.busy === 1'b1) busy_cnt++;
      end
      @(negedge CLK);
      if (!hold) bus.Data_Valid = 1'b0;
      n_checks++;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle after frame: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0",
                  name, bus.TX_OUT, bus.busy);
      end
      n_checks++;
      if (busy_cnt != (DW + 2 + ((PAR_BUILT && pe) ? 1 : 0)) * eff) begin
         n_fail++;
         $display("FAIL %s busy_len: got %0d cycles, expected %0d",
                  name, busy_cnt, (DW + 2 + ((PAR_BUILT && pe) ? 1 : 0)) * eff);
      end
   endtask

   task automatic test_reset();
      bus.P_DATA     = '0;
      bus.Data_Valid = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      bus.Prescale   = '0;
      RST            = 1'b0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0",
                  bus.TX_OUT, bus.busy);
      end
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      n_checks++;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0",
                  bus.TX_OUT, bus.busy);
      end
   endtask

   task automatic test_parity_frames();
      test_frame("a5_even_p8", 8'hA5, 1'b1, 1'b0, 8, -1, 8'h00, 1'b0);
      test_frame("00_odd_p8", 8'h00, 1'b1, 1'b1, 8, -1, 8'h00, 1'b0);
      test_frame("ff_nopar_p16", 8'hFF, 1'b0, 1'b0, 16, -1, 8'h00, 1'b0);
   endtask

   task automatic test_ignore_mid_frame();
      test_frame("5a_pulse_3c", 8'h5A, 1'b0, 1'b0, 4, 14, 8'h3C, 1'b0);
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         n_checks++;
         if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_second_frame cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0",
                     k, bus.TX_OUT, bus.busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      test_frame("b2b_81_f0", 8'h81, 1'b0, 1'b0, 4, -1, 8'h00, 1'b1);
      test_frame("b2b_81_f1", 8'h81, 1'b0, 1'b0, 4, -1, 8'h00, 1'b1);
      test_frame("b2b_81_f2", 8'h81, 1'b0, 1'b0, 4, -1, 8'h00, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         n_checks++;
         if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0",
                     k, bus.TX_OUT, bus.busy);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      d = 8'hA2;
      bus.P_DATA     = d;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      bus.Prescale   = PW'(4);
      bus.Data_Valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
      // Cycles 16..19 after acceptance carry data bit 3 at Prescale 4.
      repeat (17) @(negedge CLK);
      n_checks++;
      if (bus.TX_OUT !== d[3] || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_bit3: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=1",
                  bus.TX_OUT, bus.busy, d[3]);
      end
      #2;
      RST = 1'b0;
      #1;
      n_checks++;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_mid_frame: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0",
                  bus.TX_OUT, bus.busy);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0",
                  bus.TX_OUT, bus.busy);
      end
      test_frame("55_after_reset", 8'h55, 1'b0, 1'b0, 4, -1, 8'h00, 1'b0);
   endtask

   task automatic test_prescale_min();
      test_frame("c3_presc1", 8'hC3, 1'b0, 1'b0, 1, -1, 8'h00, 1'b0);
      test_frame("c3_presc0", 8'hC3, 1'b0, 1'b0, 0, -1, 8'h00, 1'b0);
      test_frame("c3_presc1_par", 8'hC3, 1'b1, 1'b1, 1, -1, 8'h00, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [7:0] pd;
      bit pe;
      bit pt;
      int presc;
      int pulse;
      for (int n = 0; n < 16; n++) begin
         d     = 8'($urandom);
         pd    = 8'($urandom);
         pe    = 1'($urandom);
         pt    = 1'($urandom);
         presc = int'($urandom_range(0, 5));
         pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
         test_frame("random", d, pe, pt, presc, pulse, pd, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_parity_frames();
      test_ignore_mid_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_prescale_min();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
